axi4_mem_slv: RTL and testbench
===============================

Name: axi4_mem_slv

Overview:
AXI4 memory responder for the HDL side of the QEMU PCIe bridge. It terminates the bridge master's AR/R and AW/W/B channels into a DEPTH x DATW register array. It is the BAR target used in cosim in place of user logic. Independent read and write engines share the array.

Parameters:
TAGW, 3, ID width
ADRW, 64, address width
DATW, 256, data width; all beats full width
STBW, DATW/8, strobe width
DEPTH, 64, number of DATW words in the array
BASE, 64'h0, byte address mapped to word 0

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_s_awid  in  TAGW  write ID
i_s_awaddr  in  ADRW  write byte address
i_s_awlen  in  8  beats-1
i_s_awburst  in  2  burst type
i_s_awvalid  in  1  AW valid
o_s_awready  out  1  AW ready
i_s_wdata  in  DATW  write data
i_s_wstrb  in  STBW  byte enables
i_s_wlast  in  1  last beat
i_s_wvalid  in  1  W valid
o_s_wready  out  1  W ready
o_s_bid  out  TAGW  echoed awid
o_s_bresp  out  2  write response
o_s_bvalid  out  1  B valid
i_s_bready  in  1  B ready
i_s_arid  in  TAGW  read ID
i_s_araddr  in  ADRW  read byte address
i_s_arlen  in  8  beats-1
i_s_arburst  in  2  burst type
i_s_arvalid  in  1  AR valid
o_s_arready  out  1  AR ready
o_s_rid  out  TAGW  echoed arid
o_s_rdata  out  DATW  read data
o_s_rresp  out  2  read response
o_s_rlast  out  1  last beat
o_s_rvalid  out  1  R valid
i_s_rready  in  1  R ready

Behaviour:
- Clock i_clk; reset i_rst_n is asynchronous, active-low. In reset all valid/ready outputs are 0, IDs/resp/rdata are 0, and both FSMs are IDLE. Array contents are not reset.
- Word index = (addr - BASE) >> log2(STBW). Low address bits are ignored (aligned). FIXED (00) holds the index; INCR (01) adds 1 per beat. Index arithmetic is ADRW wide with no wrap.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On the AW handshake, latch id/index/len/burst and go to W_DATA.
  - W_DATA: wready=1. Each handshake writes the bytes whose strobe is set, on that edge. Beat count reaches awlen -> W_RESP.
  - W_RESP: bvalid=1 until bready, then W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On the AR handshake, latch fields. First rvalid appears the next cycle (1-cycle latency).
  - R_DATA: rdata is registered. While rvalid && !rready, rdata/rresp/rlast hold stable. The next beat is presented the cycle after each handshake, so there is no bubble under continuous rready. rlast=1 on beat arlen. Handshake on the last beat -> R_IDLE.
- Response codes:
  - Any beat with index >= DEPTH: DECERR (2'b11). Its write is dropped; its read data is 0.
  - WRAP (10) or reserved (11) burst: SLVERR (2'b10) for every beat. Writes are dropped; reads return 0.
  - wlast disagreeing with the beat count: SLVERR. The burst still ends on the count.
  - bresp reports the worst beat: DECERR > SLVERR > OKAY.
- Simultaneous read and write of the same word in one cycle: the read returns the old data.
- Reset asserted mid-burst aborts both FSMs immediately. No B or R response is issued for the aborted burst.
- awready/arready are 0 outside IDLE, so there is at most one outstanding transaction per direction.

Optional Feature:
AXI4_MEM_SLV_STALL_EN
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5; advances every cycle after reset) gates the outputs. When lfsr[0]=1, wready is forced to 0 and no new R beat is launched. A beat already presented keeps rvalid high.
- Undefined: no stalls; timing is as above.

Decomposition:
- Package axi4_mem_slv_pkg holds:
  - burst enum (FIXED/INCR/WRAP);
  - resp constants OKAY/EXOKAY/SLVERR/DECERR;
  - write and read FSM state enums;
  - a worst-resp merge function.
- One sub-module, axi4_mem_slv_lfsr, generates the stall pattern. It is instantiated only under the macro.

Test Plan:
- INCR write at BASE+0, awlen=3, data 0x11..,0x22..,0x33..,0x44.., wstrb all ones, then INCR read awlen=3 -> the same 4 words, rlast on beat 4 only, rresp=OKAY, bresp=OKAY.
- Write wstrb=32'h0000_000F of 0xDEADBEEF to word 5, then read word 5 -> low 4 bytes = DEADBEEF, remaining bytes unchanged.
- INCR write of 4 beats starting at word DEPTH-2 -> bresp=DECERR; a read of words DEPTH-2..DEPTH-1 returns the new data for those two words.
- WRAP read, arlen=1 -> 2 beats of rdata=0 with rresp=SLVERR; write with wlast asserted on beat 1 of 3 -> bresp=SLVERR.
- rready held low for 5 cycles mid-burst -> rdata/rlast stable throughout; reset pulsed during W_DATA -> bvalid never asserts, and awready=1 after release.

Source files
------------

// File: rtl/axi4_mem_slv_pkg.sv
// axi4_mem_slv_pkg: shared types for the AXI4 memory responder.
//   burst_e    : AXI burst encodings (FIXED/INCR/WRAP, 2'b11 reserved)
//   RESP_*     : AXI response codes
//   wr_st_e    : write engine states
//   rd_st_e    : read engine states
//   resp_worst : merge two responses, keeping the more severe one
package axi4_mem_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_st_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_st_e;

  // Response codes are numerically ordered by severity (DECERR > SLVERR > OKAY).
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_mem_slv_lfsr.sv
// axi4_mem_slv_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) that
// advances every cycle out of reset; bit 0 is used as a stall request.
//   i_clk   : clock
//   i_rst_n : async active-low reset
//   o_lfsr  : current LFSR state
module axi4_mem_slv_lfsr (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [7:0] o_lfsr
);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_lfsr <= 8'hA5;
    else          o_lfsr <= {o_lfsr[6:0], o_lfsr[7] ^ o_lfsr[5] ^ o_lfsr[4] ^ o_lfsr[3]};

endmodule

// File: rtl/axi4_mem_slv.sv
// axi4_mem_slv: AXI4 memory responder (BAR target for the PCIe bridge cosim).
// Independent read and write engines share a DEPTH x DATW register array.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_s_aw* / o_s_awready     : write address channel
//   i_s_w*  / o_s_wready      : write data channel
//   o_s_b*  / i_s_bready      : write response channel
//   i_s_ar* / o_s_arready     : read address channel
//   o_s_r*  / i_s_rready      : read data channel
// Optional build macro AXI4_MEM_SLV_STALL_EN: an LFSR randomly withholds
// wready and delays launching new R beats.
module axi4_mem_slv
  import axi4_mem_slv_pkg::*;
#(
  parameter int              TAGW  = 3,
  parameter int              ADRW  = 64,
  parameter int              DATW  = 256,
  parameter int              STBW  = DATW / 8,
  parameter int              DEPTH = 64,
  parameter logic [ADRW-1:0] BASE  = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [TAGW-1:0] i_s_awid,
  input  logic [ADRW-1:0] i_s_awaddr,
  input  logic [7:0]      i_s_awlen,
  input  logic [1:0]      i_s_awburst,
  input  logic            i_s_awvalid,
  output logic            o_s_awready,
  input  logic [DATW-1:0] i_s_wdata,
  input  logic [STBW-1:0] i_s_wstrb,
  input  logic            i_s_wlast,
  input  logic            i_s_wvalid,
  output logic            o_s_wready,
  output logic [TAGW-1:0] o_s_bid,
  output logic [1:0]      o_s_bresp,
  output logic            o_s_bvalid,
  input  logic            i_s_bready,
  input  logic [TAGW-1:0] i_s_arid,
  input  logic [ADRW-1:0] i_s_araddr,
  input  logic [7:0]      i_s_arlen,
  input  logic [1:0]      i_s_arburst,
  input  logic            i_s_arvalid,
  output logic            o_s_arready,
  output logic [TAGW-1:0] o_s_rid,
  output logic [DATW-1:0] o_s_rdata,
  output logic [1:0]      o_s_rresp,
  output logic            o_s_rlast,
  output logic            o_s_rvalid,
  input  logic            i_s_rready
);

  localparam int              OFFW    = $clog2(STBW);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [ADRW-1:0] DEPTH_A = ADRW'(DEPTH);

  logic [DATW-1:0] mem [DEPTH];
  logic            stall;

`ifdef AXI4_MEM_SLV_STALL_EN
  logic [7:0] lfsr;
  axi4_mem_slv_lfsr u_lfsr (.i_clk(i_clk), .i_rst_n(i_rst_n), .o_lfsr(lfsr));
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // ---------------- write engine ----------------
  wr_st_e          w_st;
  logic [ADRW-1:0] w_idx;
  logic [7:0]      w_len, w_cnt;
  logic [1:0]      w_burst, w_resp, w_beat_resp;
  logic            awready_q, wready_q;
  logic            aw_hs, w_hs, w_last_beat, w_in_rng, w_bad, w_we;

  assign o_s_awready = awready_q;
  assign o_s_wready  = wready_q & ~stall;

  always_comb begin
    aw_hs       = i_s_awvalid & awready_q;
    w_hs        = i_s_wvalid & o_s_wready;
    w_last_beat = (w_cnt == w_len);
    w_in_rng    = (w_idx < DEPTH_A);
    w_bad       = (w_burst != BURST_FIXED) && (w_burst != BURST_INCR);
    w_we        = w_hs & w_in_rng & ~w_bad;
    w_beat_resp = resp_worst(w_bad ? RESP_SLVERR : RESP_OKAY,
                             w_in_rng ? RESP_OKAY : RESP_DECERR);
    // wlast mismatch is flagged but the burst length still comes from awlen
    if (i_s_wlast != w_last_beat) w_beat_resp = resp_worst(w_beat_resp, RESP_SLVERR);
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      w_st       <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      o_s_bvalid <= 1'b0;
      o_s_bid    <= '0;
      o_s_bresp  <= '0;
      w_idx      <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_burst    <= '0;
      w_resp     <= '0;
    end else begin
      case (w_st)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            o_s_bid   <= i_s_awid;
            w_idx     <= (i_s_awaddr - BASE) >> OFFW;
            w_len     <= i_s_awlen;
            w_burst   <= i_s_awburst;
            w_cnt     <= '0;
            w_resp    <= RESP_OKAY;
            w_st      <= W_DATA;
          end
        end
        W_DATA: if (w_hs) begin
          w_resp <= resp_worst(w_resp, w_beat_resp);
          w_cnt  <= w_cnt + 8'd1;
          if (w_burst == BURST_INCR) w_idx <= w_idx + 1'b1;
          if (w_last_beat) begin
            wready_q   <= 1'b0;
            o_s_bvalid <= 1'b1;
            o_s_bresp  <= resp_worst(w_resp, w_beat_resp);
            w_st       <= W_RESP;
          end
        end
        W_RESP: if (i_s_bready) begin
          o_s_bvalid <= 1'b0;
          awready_q  <= 1'b1;
          w_st       <= W_IDLE;
        end
        default: w_st <= W_IDLE;
      endcase
    end

  // Array is not reset; byte lanes written on the W handshake edge.
  always_ff @(posedge i_clk)
    if (w_we)
      for (int b = 0; b < STBW; b++)
        if (i_s_wstrb[b]) mem[w_idx[AW-1:0]][8*b +: 8] <= i_s_wdata[8*b +: 8];

  // ---------------- read engine ----------------
  rd_st_e          r_st;
  logic [ADRW-1:0] r_idx, l_idx;
  logic [7:0]      r_len, r_cnt, l_len, l_cnt;
  logic [1:0]      r_burst, l_burst, l_resp;
  logic [DATW-1:0] l_data;
  logic            arready_q, idle, ar_hs, r_hs, l_in_rng, l_bad, launch;

  assign o_s_arready = arready_q;

  // The beat to launch comes straight from AR in IDLE (1-cycle latency),
  // otherwise from the running burst state. Reading the array on the launch
  // edge gives old data when a write hits the same word in the same cycle.
  always_comb begin
    idle     = (r_st == R_IDLE);
    ar_hs    = i_s_arvalid & arready_q;
    r_hs     = o_s_rvalid & i_s_rready;
    l_idx    = idle ? ((i_s_araddr - BASE) >> OFFW) : r_idx;
    l_cnt    = idle ? 8'd0 : r_cnt;
    l_len    = idle ? i_s_arlen : r_len;
    l_burst  = idle ? i_s_arburst : r_burst;
    l_in_rng = (l_idx < DEPTH_A);
    l_bad    = (l_burst != BURST_FIXED) && (l_burst != BURST_INCR);
    l_resp   = resp_worst(l_bad ? RESP_SLVERR : RESP_OKAY,
                          l_in_rng ? RESP_OKAY : RESP_DECERR);
    l_data   = (l_in_rng && !l_bad) ? mem[l_idx[AW-1:0]] : '0;
    launch   = ~stall & (idle ? ar_hs : (~o_s_rvalid | (r_hs & ~o_s_rlast)));
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_st       <= R_IDLE;
      arready_q  <= 1'b0;
      o_s_rvalid <= 1'b0;
      o_s_rid    <= '0;
      o_s_rdata  <= '0;
      o_s_rresp  <= '0;
      o_s_rlast  <= 1'b0;
      r_idx      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_burst    <= '0;
    end else begin
      if (idle) begin
        arready_q <= 1'b1;
        if (ar_hs) begin
          arready_q <= 1'b0;
          o_s_rid   <= i_s_arid;
          r_len     <= i_s_arlen;
          r_burst   <= i_s_arburst;
          r_idx     <= l_idx;
          r_cnt     <= '0;
          r_st      <= R_DATA;
        end
      end else if (r_hs && o_s_rlast) begin
        o_s_rvalid <= 1'b0;
        arready_q  <= 1'b1;
        r_st       <= R_IDLE;
      end else if (r_hs) begin
        o_s_rvalid <= 1'b0;
      end
      if (launch) begin
        o_s_rvalid <= 1'b1;
        o_s_rdata  <= l_data;
        o_s_rresp  <= l_resp;
        o_s_rlast  <= (l_cnt == l_len);
        r_idx      <= (l_burst == BURST_INCR) ? l_idx + 1'b1 : l_idx;
        r_cnt      <= l_cnt + 8'd1;
      end
    end

endmodule

// File: tb/tb_axi4_mem_slv.sv
// Self-checking bench for axi4_mem_slv: expected B and R responses are queued
// when stimulus is issued, and a negedge monitor pops and compares them.
module tb_axi4_mem_slv;
  import axi4_mem_slv_pkg::*;

  localparam int TAGW = 3, ADRW = 64, DATW = 256, STBW = 32, DEPTH = 64;

  logic            clk, rst_n;
  logic [TAGW-1:0] awid, arid, bid, rid;
  logic [ADRW-1:0] awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [DATW-1:0] wdata, rdata;
  logic [STBW-1:0] wstrb;

  axi4_mem_slv #(.TAGW(TAGW), .ADRW(ADRW), .DATW(DATW), .STBW(STBW), .DEPTH(DEPTH), .BASE(64'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_awid(awid), .i_s_awaddr(awaddr), .i_s_awlen(awlen), .i_s_awburst(awburst),
    .i_s_awvalid(awvalid), .o_s_awready(awready),
    .i_s_wdata(wdata), .i_s_wstrb(wstrb), .i_s_wlast(wlast), .i_s_wvalid(wvalid), .o_s_wready(wready),
    .o_s_bid(bid), .o_s_bresp(bresp), .o_s_bvalid(bvalid), .i_s_bready(bready),
    .i_s_arid(arid), .i_s_araddr(araddr), .i_s_arlen(arlen), .i_s_arburst(arburst),
    .i_s_arvalid(arvalid), .o_s_arready(arready),
    .o_s_rid(rid), .o_s_rdata(rdata), .o_s_rresp(rresp), .o_s_rlast(rlast),
    .o_s_rvalid(rvalid), .i_s_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [TAGW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [TAGW-1:0] id; logic [DATW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  b_exp_t be;
  r_exp_t re;
  int checks = 0, errors = 0;

  logic [DATW-1:0] wd [8];
  logic [STBW-1:0] ws [8];
  logic            wl [8];

  task automatic chk(input string name, input logic [DATW-1:0] act, input logic [DATW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every B/R handshake against the head of its queue.
  always @(negedge clk) if (rst_n) begin
    if (bvalid && bready) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected got id=%0d resp=%0d", bid, bresp);
      end else begin
        be = bq.pop_front();
        if (bid !== be.id || bresp !== be.resp) begin
          errors++;
          $display("FAIL b_beat got id=%0d resp=%0d want id=%0d resp=%0d", bid, bresp, be.id, be.resp);
        end
      end
    end
    if (rvalid && rready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected got id=%0d resp=%0d", rid, rresp);
      end else begin
        re = rq.pop_front();
        if (rid !== re.id || rdata !== re.data || rresp !== re.resp || rlast !== re.last) begin
          errors++;
          $display("FAIL r_beat got id=%0d resp=%0d last=%0d data=%h want id=%0d resp=%0d last=%0d data=%h",
                   rid, rresp, rlast, rdata, re.id, re.resp, re.last, re.data);
        end
      end
    end
  end

  task automatic push_r(input logic [TAGW-1:0] id, input logic [DATW-1:0] d, input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    rq.push_back(e);
  endtask

  task automatic aw_send(input logic [TAGW-1:0] id, input logic [ADRW-1:0] a, input logic [7:0] len, input logic [1:0] bu);
    logic rdy;
    int n = 0;
    awid = id; awaddr = a; awlen = len; awburst = bu; awvalid = 1'b1;
    do begin @(negedge clk); rdy = awready; @(posedge clk); #1; n++; end while (!rdy && n < 100);
    awvalid = 1'b0;
    if (!rdy) begin checks++; errors++; $display("FAIL aw_timeout got=0 want=awready"); end
  endtask

  task automatic w_beat(input logic [DATW-1:0] d, input logic [STBW-1:0] s, input logic l);
    logic rdy;
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    do begin @(negedge clk); rdy = wready; @(posedge clk); #1; n++; end while (!rdy && n < 100);
    if (!rdy) begin checks++; errors++; $display("FAIL w_timeout got=0 want=wready"); end
  endtask

  task automatic ar_send(input logic [TAGW-1:0] id, input logic [ADRW-1:0] a, input logic [7:0] len, input logic [1:0] bu);
    logic rdy;
    int n = 0;
    arid = id; araddr = a; arlen = len; arburst = bu; arvalid = 1'b1;
    do begin @(negedge clk); rdy = arready; @(posedge clk); #1; n++; end while (!rdy && n < 100);
    arvalid = 1'b0;
    if (!rdy) begin checks++; errors++; $display("FAIL ar_timeout got=0 want=arready"); end
  endtask

  // Write burst using wd/ws/wl for the beats; expected B queued up front.
  task automatic wr_burst(input logic [TAGW-1:0] id, input logic [ADRW-1:0] a, input logic [7:0] len,
                          input logic [1:0] bu, input logic [1:0] exp);
    b_exp_t e;
    e.id = id; e.resp = exp;
    bq.push_back(e);
    aw_send(id, a, len, bu);
    for (int i = 0; i <= int'(len); i++) w_beat(wd[i], ws[i], wl[i]);
    wvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 300) begin @(posedge clk); n++; end
    #1;
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout got b=%0d r=%0d pending want 0", bq.size(), rq.size());
    end
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    if (!rvalid) begin checks++; errors++; $display("FAIL rvalid_timeout got=0 want=1"); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  logic [DATW-1:0] cap_data;
  logic [3:0]      cap_ctl;
  logic            saw_b;

  initial begin
    rst_n = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1'b1; rready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; arid = '0; araddr = '0; arlen = '0; arburst = '0;
    wdata = '0; wstrb = '0; wlast = 0;
    #2;
    chk("rst_ready", {awready, wready, arready}, '0);
    chk("rst_valid", {bvalid, rvalid}, '0);
    chk("rst_ids", {bid, rid, bresp, rresp}, '0);
    chk("rst_rdata", rdata, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", {awready, arready}, 2'b11);

    // INCR 4-beat write then read back
    wd[0] = {32{8'h11}}; wd[1] = {32{8'h22}}; wd[2] = {32{8'h33}}; wd[3] = {32{8'h44}};
    for (int i = 0; i < 4; i++) begin ws[i] = '1; wl[i] = (i == 3); end
    wr_burst(3'd1, 64'h0, 8'd3, BURST_INCR, RESP_OKAY);
    wait_drain();
    for (int i = 0; i < 4; i++) push_r(3'd2, wd[i], RESP_OKAY, i == 3);
    ar_send(3'd2, 64'h0, 8'd3, BURST_INCR);
    wait_drain();

    // Partial strobe on word 5
    wd[0] = {32{8'h5A}}; ws[0] = '1; wl[0] = 1'b1;
    wr_burst(3'd3, 64'hA0, 8'd0, BURST_INCR, RESP_OKAY);
    wd[0] = 256'hDEADBEEF; ws[0] = 32'h0000_000F;
    wr_burst(3'd4, 64'hA0, 8'd0, BURST_INCR, RESP_OKAY);
    wait_drain();
    push_r(3'd5, {{28{8'h5A}}, 32'hDEADBEEF}, RESP_OKAY, 1'b1);
    ar_send(3'd5, 64'hA0, 8'd0, BURST_INCR);
    wait_drain();

    // Burst running off the end of the array
    wd[0] = {32{8'hA0}}; wd[1] = {32{8'hA1}}; wd[2] = {32{8'hA2}}; wd[3] = {32{8'hA3}};
    for (int i = 0; i < 4; i++) begin ws[i] = '1; wl[i] = (i == 3); end
    wr_burst(3'd6, 64'h7C0, 8'd3, BURST_INCR, RESP_DECERR);
    wait_drain();
    push_r(3'd7, {32{8'hA0}}, RESP_OKAY, 1'b0);
    push_r(3'd7, {32{8'hA1}}, RESP_OKAY, 1'b1);
    ar_send(3'd7, 64'h7C0, 8'd1, BURST_INCR);
    wait_drain();
    push_r(3'd0, '0, RESP_DECERR, 1'b1);
    ar_send(3'd0, 64'h800, 8'd0, BURST_INCR);
    wait_drain();

    // WRAP read and misplaced wlast
    push_r(3'd1, '0, RESP_SLVERR, 1'b0);
    push_r(3'd1, '0, RESP_SLVERR, 1'b1);
    ar_send(3'd1, 64'h0, 8'd1, BURST_WRAP);
    wait_drain();
    wd[0] = {32{8'hC0}}; wd[1] = {32{8'hC1}}; wd[2] = {32{8'hC2}};
    for (int i = 0; i < 3; i++) begin ws[i] = '1; wl[i] = (i == 1); end
    wr_burst(3'd2, 64'h140, 8'd2, BURST_INCR, RESP_SLVERR);
    wait_drain();

    // FIXED burst: both beats land on word 20
    wd[0] = {32{8'h77}}; ws[0] = '1; wl[0] = 1'b0;
    wd[1] = 256'h88;     ws[1] = 32'h1; wl[1] = 1'b1;
    wr_burst(3'd3, 64'h280, 8'd1, BURST_FIXED, RESP_OKAY);
    wait_drain();
    push_r(3'd4, {{31{8'h77}}, 8'h88}, RESP_OKAY, 1'b0);
    push_r(3'd4, {{31{8'h77}}, 8'h88}, RESP_OKAY, 1'b1);
    ar_send(3'd4, 64'h280, 8'd1, BURST_FIXED);
    wait_drain();

    // rready held low mid-burst: presented beat must hold
    for (int i = 0; i < 4; i++) push_r(3'd5, {32{8'(8'h11 * (i + 1))}}, RESP_OKAY, i == 3);
    rready = 1'b0;
    ar_send(3'd5, 64'h0, 8'd3, BURST_INCR);
    wait_rvalid();
    @(posedge clk); #1; rready = 1'b1;
    @(posedge clk); #1; rready = 1'b0;
    @(negedge clk);
    wait_rvalid();
    cap_data = rdata; cap_ctl = {rvalid, rlast, rresp};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rhold_data", rdata, cap_data);
      chk("rhold_ctl", {rvalid, rlast, rresp}, cap_ctl);
    end
    @(posedge clk); #1; rready = 1'b1;
    wait_drain();

    // Reset in the middle of a write burst
    aw_send(3'd6, 64'h300, 8'd3, BURST_INCR);
    w_beat({32{8'hE0}}, '1, 1'b0);
    w_beat({32{8'hE1}}, '1, 1'b0);
    wvalid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("abort_outs", {bvalid, wready, awready, rvalid}, '0);
    @(negedge clk); rst_n = 1'b1;
    saw_b = 1'b0;
    repeat (10) begin @(negedge clk); if (bvalid) saw_b = 1'b1; end
    chk("abort_no_b", saw_b, 1'b0);
    chk("abort_awready", awready, 1'b1);
    @(posedge clk); #1;

    // Recovery: earlier data still readable
    push_r(3'd7, {32{8'h11}}, RESP_OKAY, 1'b1);
    ar_send(3'd7, 64'h0, 8'd0, BURST_INCR);
    wait_drain();

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
